tx_nco: RTL and testbench

Numerically controlled oscillator for the DSP transmit chain. It sits directly downstream of the PLL/reset generator and consumes that block's `clk` and `rst`. It runs a phase accumulator with a tuning word and a phase offset, and produces square-wave I/Q carrier codes, a truncated phase for downstream LUT/mixer stages, and a wrap strobe. The tuning word and offset arrive through a valid/ready handshake. They are applied either phase-continuously at the next accumulator wrap, or immediately with a phase reset.

---
 rtl/tx_dsp_pkg.sv | 14 +
 rtl/phase_acc.sv | 43 ++++
 rtl/tx_nco.sv | 132 +++++++++++++
 tb/tb_tx_nco.sv | 224 ++++++++++++++++++++++
 4 files changed

// File: rtl/tx_dsp_pkg.sv
// Shared definitions for the transmit DSP chain: default widths, the
// out-of-reset tuning word and the NCO configuration FSM states.
package tx_dsp_pkg;

  localparam int unsigned ACC_W_DEF   = 16;
  localparam int unsigned PH_W_DEF    = 8;
  localparam logic [15:0] FCW_RST_DEF = 16'h3300;

  typedef enum logic {
    IDLE    = 1'b0,
    PENDING = 1'b1
  } nco_state_e;

endpackage

// File: rtl/phase_acc.sv
// Phase accumulator: advances by the tuning word and exposes the carry, plus
// the offset phase computed from the pre-update accumulator value.
module phase_acc
  import tx_dsp_pkg::*;
#(
  parameter int unsigned ACC_W = ACC_W_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             clr,
  input  logic [ACC_W-1:0] fcw,
  input  logic [ACC_W-1:0] pcw,
  output logic [ACC_W-1:0] ph,
  output logic             carry
);

  logic [ACC_W-1:0] acc_q, acc_d;
  logic [ACC_W:0]   sum;

  assign sum   = {1'b0, acc_q} + {1'b0, fcw};
  assign carry = sum[ACC_W];
  assign ph    = acc_q + pcw;

  // Clear wins over advance so a phase-reset load lands on zero regardless of en.
  always_comb begin
    acc_d = acc_q;
    if (clr) begin
      acc_d = '0;
    end else if (en) begin
      acc_d = sum[ACC_W-1:0];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc_q <= '0;
    end else begin
      acc_q <= acc_d;
    end
  end

endmodule

// File: rtl/tx_nco.sv
// Transmit NCO: square I/Q carrier, truncated phase and wrap strobe, with a
// valid/ready configuration port that loads either at the next wrap or at once.
module tx_nco
  import tx_dsp_pkg::*;
#(
  parameter int unsigned      ACC_W   = ACC_W_DEF,
  parameter int unsigned      PH_W    = PH_W_DEF,
  parameter logic [ACC_W-1:0] FCW_RST = ACC_W'(FCW_RST_DEF)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             cfg_valid,
  output logic             cfg_ready,
  input  logic [ACC_W-1:0] cfg_fcw,
  input  logic [ACC_W-1:0] cfg_pcw,
  input  logic             cfg_sync,
  output logic             i_code,
  output logic             q_code,
  output logic [PH_W-1:0]  phase_out,
  output logic             wrap
);

  nco_state_e state_q, state_d;

  logic             cfg_ready_q, cfg_ready_d;
  logic             accept, load_sync, load_shadow, apply_shadow;
  logic [ACC_W-1:0] fcw_act_q, fcw_act_d, pcw_act_q, pcw_act_d;
  logic [ACC_W-1:0] fcw_sh_q, fcw_sh_d, pcw_sh_q, pcw_sh_d;
  logic [ACC_W-1:0] ph;
  logic             carry;

  logic             i_code_q, q_code_q, wrap_q;
  logic [PH_W-1:0]  phase_q;

  assign accept = cfg_valid & cfg_ready_q;

  phase_acc #(
    .ACC_W (ACC_W)
  ) u_phase_acc (
    .clk   (clk),
    .rst   (rst),
    .en    (en),
    .clr   (load_sync),
    .fcw   (fcw_act_q),
    .pcw   (pcw_act_q),
    .ph    (ph),
    .carry (carry)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (accept && !cfg_sync) state_d = PENDING;
      PENDING: if (apply_shadow)        state_d = IDLE;
      default:                          state_d = IDLE;
    endcase
  end

  // A zero tuning word never wraps, so a pending load applies on the next enabled edge.
  always_comb begin
    load_sync    = (state_q == IDLE) && accept && cfg_sync;
    load_shadow  = (state_q == IDLE) && accept && !cfg_sync;
    apply_shadow = (state_q == PENDING) && en && (carry || (fcw_act_q == '0));
    cfg_ready_d  = (state_d == IDLE);
  end

  always_comb begin
    fcw_act_d = fcw_act_q;
    pcw_act_d = pcw_act_q;
    fcw_sh_d  = fcw_sh_q;
    pcw_sh_d  = pcw_sh_q;
    if (load_sync) begin
      fcw_act_d = cfg_fcw;
      pcw_act_d = cfg_pcw;
    end else if (apply_shadow) begin
      fcw_act_d = fcw_sh_q;
      pcw_act_d = pcw_sh_q;
    end
    if (load_shadow) begin
      fcw_sh_d = cfg_fcw;
      pcw_sh_d = cfg_pcw;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cfg_ready_q <= 1'b0;
      fcw_act_q   <= FCW_RST;
      pcw_act_q   <= '0;
      fcw_sh_q    <= '0;
      pcw_sh_q    <= '0;
    end else begin
      cfg_ready_q <= cfg_ready_d;
      fcw_act_q   <= fcw_act_d;
      pcw_act_q   <= pcw_act_d;
      fcw_sh_q    <= fcw_sh_d;
      pcw_sh_q    <= pcw_sh_d;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      i_code_q <= 1'b0;
      q_code_q <= 1'b0;
      phase_q  <= '0;
      wrap_q   <= 1'b0;
    end else if (en) begin
      i_code_q <= ph[ACC_W-1];
      q_code_q <= ph[ACC_W-1] ^ ph[ACC_W-2];
      phase_q  <= ph[ACC_W-1 -: PH_W];
      wrap_q   <= carry;
    end else begin
      wrap_q   <= 1'b0;
    end
  end

  assign cfg_ready = cfg_ready_q;
  assign i_code    = i_code_q;
  assign q_code    = q_code_q;
  assign phase_out = phase_q;
  assign wrap      = wrap_q;

endmodule

// File: tb/tb_tx_nco.sv
// Self-checking bench for tx_nco: directed scenarios followed by random
// configuration traffic, all compared against an arithmetic reference model.
module tb_tx_nco;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        en = 1'b0;
  logic        cfg_valid = 1'b0;
  logic        cfg_sync = 1'b0;
  logic [15:0] cfg_fcw = '0;
  logic [15:0] cfg_pcw = '0;
  logic        cfg_ready, i_code, q_code, wrap;
  logic [7:0]  phase_out;

  int n_checks = 0;
  int n_fail   = 0;
  int step_no  = 0;
  int wraps_q[$];

  // Reference model state, held as plain integers.
  int unsigned m_acc, m_fcw, m_pcw, m_fcw_sh, m_pcw_sh, m_phase;
  bit          m_pending, m_ready, m_i, m_q, m_wrap;

  always #5 clk = ~clk;

  tx_nco dut (
    .clk       (clk),
    .rst       (rst),
    .en        (en),
    .cfg_valid (cfg_valid),
    .cfg_ready (cfg_ready),
    .cfg_fcw   (cfg_fcw),
    .cfg_pcw   (cfg_pcw),
    .cfg_sync  (cfg_sync),
    .i_code    (i_code),
    .q_code    (q_code),
    .phase_out (phase_out),
    .wrap      (wrap)
  );

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s step=%0d got=%0h expected=%0h", tag, step_no, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_acc = 0; m_fcw = 32'h3300; m_pcw = 0; m_fcw_sh = 0; m_pcw_sh = 0;
    m_pending = 0; m_ready = 0; m_i = 0; m_q = 0; m_wrap = 0; m_phase = 0;
  endtask

  task automatic model_edge(input bit v, input int unsigned f, input int unsigned p,
                            input bit s, input bit e);
    int unsigned sum, ph, quad, acc_next;
    bit          carry, accept;
    accept   = v && m_ready;
    sum      = m_acc + m_fcw;
    carry    = (sum >= 32'h10000);
    ph       = (m_acc + m_pcw) % 32'h10000;
    quad     = ph / 32'h4000;
    acc_next = e ? sum % 32'h10000 : m_acc;
    if (e) begin
      m_phase = ph / 256;
      m_i     = (quad >= 2);
      m_q     = (quad == 1) || (quad == 2);
      m_wrap  = carry;
    end else begin
      m_wrap  = 0;
    end
    if (!m_pending) begin
      if (accept && s) begin
        m_fcw = f; m_pcw = p; acc_next = 0;
      end else if (accept) begin
        m_fcw_sh = f; m_pcw_sh = p; m_pending = 1;
      end
    end else if (e && (carry || m_fcw == 0)) begin
      m_fcw = m_fcw_sh; m_pcw = m_pcw_sh; m_pending = 0;
    end
    m_acc   = acc_next;
    m_ready = !m_pending;
  endtask

  task automatic check_outputs();
    check_val("cfg_ready", {31'b0, cfg_ready}, {31'b0, m_ready});
    check_val("i_code",    {31'b0, i_code},    {31'b0, m_i});
    check_val("q_code",    {31'b0, q_code},    {31'b0, m_q});
    check_val("phase_out", {24'b0, phase_out}, m_phase);
    check_val("wrap",      {31'b0, wrap},      {31'b0, m_wrap});
  endtask

  // Called at a falling edge; applies one rising edge and checks at the next falling edge.
  task automatic step(input bit v, input logic [15:0] f, input logic [15:0] p,
                      input bit s, input bit e);
    cfg_valid = v; cfg_fcw = f; cfg_pcw = p; cfg_sync = s; en = e;
    if (v && m_ready)
      $display("cfg step=%0d fcw=%04h pcw=%04h sync=%0d en=%0d", step_no + 1, f, p, s, e);
    model_edge(v, f, p, s, e);
    @(posedge clk);
    @(negedge clk);
    cfg_valid = 1'b0;
    step_no++;
    check_outputs();
    if (wrap) wraps_q.push_back(step_no);
  endtask

  task automatic run(input int n, input bit e);
    for (int k = 0; k < n; k++) step(1'b0, 16'h0, 16'h0, 1'b0, e);
  endtask

  // Asserts reset between edges so the outputs must clear without a clock.
  task automatic pulse_reset();
    #2 rst = 1'b1;
    #1 model_reset();
    check_outputs();
    @(negedge clk);
    rst = 1'b0;
    check_outputs();
  endtask

  initial begin : main
    int first_wrap, low_cnt, gap, n;
    bit reached;
    model_reset();
    @(negedge clk);
    check_outputs();
    rst = 1'b0;

    // Free-running at the reset tuning word: first wrap after the 6th add.
    wraps_q.delete();
    run(20, 1'b1);
    first_wrap = (wraps_q.size() > 0) ? wraps_q[0] : -1;
    check_val("first_wrap_rst_fcw", first_wrap, 6);

    // Phase-reset load of 0x1000: 16-cycle period.
    step(1'b1, 16'h1000, 16'h0000, 1'b1, 1'b1);
    wraps_q.delete();
    run(40, 1'b1);
    n = wraps_q.size();
    gap = (n >= 2) ? wraps_q[n-1] - wraps_q[n-2] : -1;
    check_val("period_fcw_1000", gap, 16);

    // Phase-continuous change to 0x2000 issued so the accumulator reads 0x8000 after it.
    reached = 0;
    for (int k = 0; k < 32 && !reached; k++) begin
      if (m_acc == 32'h7000) reached = 1;
      else step(1'b0, 16'h0, 16'h0, 1'b0, 1'b1);
    end
    check_val("acc_align", {31'b0, reached}, 1);
    step(1'b1, 16'h2000, 16'h0000, 1'b0, 1'b1);
    low_cnt = cfg_ready ? 0 : 1;
    wraps_q.delete();
    for (int k = 0; k < 20; k++) begin
      step(1'b0, 16'h0, 16'h0, 1'b0, 1'b1);
      if (!cfg_ready) low_cnt++;
    end
    check_val("ready_low_cycles", low_cnt, 8);
    n = wraps_q.size();
    gap = (n >= 2) ? wraps_q[n-1] - wraps_q[n-2] : -1;
    check_val("period_fcw_2000", gap, 8);

    // Phase offset 0x4000 via sync: first output phase is 0x40.
    step(1'b1, 16'h1000, 16'h4000, 1'b1, 1'b1);
    step(1'b0, 16'h0, 16'h0, 1'b0, 1'b1);
    check_val("pcw_first_phase", {24'b0, phase_out}, 32'h40);
    run(10, 1'b1);

    // Enable dropped for 5 cycles while a load is pending.
    step(1'b1, 16'h0800, 16'h1000, 1'b0, 1'b1);
    run(5, 1'b0);
    check_val("pending_hold_ready", {31'b0, cfg_ready}, 0);
    run(40, 1'b1);

    // Zero tuning word: pending load applies on the first enabled edge.
    step(1'b1, 16'h0000, 16'h0000, 1'b1, 1'b1);
    step(1'b1, 16'h2000, 16'h0000, 1'b0, 1'b1);
    run(3, 1'b0);
    step(1'b0, 16'h0, 16'h0, 1'b0, 1'b1);
    check_val("fcw0_apply_ready", {31'b0, cfg_ready}, 1);
    run(12, 1'b1);

    // Reset while pending: shadow discarded, period follows the reset word again.
    step(1'b1, 16'h0100, 16'h0000, 1'b0, 1'b1);
    run(3, 1'b1);
    pulse_reset();
    wraps_q.delete();
    step_no = 0;
    run(30, 1'b1);
    first_wrap = (wraps_q.size() > 0) ? wraps_q[0] : -1;
    check_val("first_wrap_after_rst", first_wrap, 6);
    n = wraps_q.size();
    gap = (n >= 2) ? wraps_q[1] - wraps_q[0] : -1;
    check_val("period_after_rst", gap, 5);

    // Random traffic.
    for (int k = 0; k < 3000; k++) begin
      logic [15:0] f, p;
      bit v, s, e;
      v = ($urandom_range(0, 3) == 0);
      s = $urandom_range(0, 1);
      e = ($urandom_range(0, 7) != 0);
      case ($urandom_range(0, 3))
        0:       f = 16'($urandom_range(0, 65535));
        1:       f = 16'($urandom_range(0, 255));
        2:       f = 16'h0000;
        default: f = 16'($urandom_range(0, 16'h1fff));
      endcase
      p = 16'($urandom_range(0, 65535));
      step(v, f, p, s, e);
      if (k == 1500) pulse_reset();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog timeout got=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
